// File: rtl/seqgen_tx.sv
// Serial pattern transmitter: shifts a WIDTH-bit pattern out MSB-first, with
// optional repetitions separated by idle gaps. Every output is a flop.
module seqgen_tx #(
  parameter int               WIDTH       = 5,
  parameter logic [WIDTH-1:0] DEFAULT_PAT = 5'b10001,
  parameter logic             IDLE_BIT    = 1'b0,
  parameter int               CNT_W       = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] pat_in,
  input  logic             start,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic [CNT_W-1:0] gap,
  output logic             dout,
  output logic             busy,
  output logic             frame_start,
  output logic             done,
  output logic [1:0]       o_dbg_state
);

  localparam int BCW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t           r_state, w_state_n;
  logic [WIDTH-1:0] r_pat, w_pat_n;
  logic [WIDTH-1:0] r_shreg, w_shreg_n;
  logic [CNT_W-1:0] r_rep, w_rep_n;
  logic [CNT_W-1:0] r_gap_len, w_gap_len_n;
  logic [CNT_W-1:0] r_gap_cnt, w_gap_cnt_n;
  logic [BCW-1:0]   r_bit_cnt, w_bit_cnt_n;
  logic             w_dout_n, w_busy_n, w_fs_n, w_done_n;
  logic [WIDTH-1:0] w_src;

  // A simultaneous load and start transmits the freshly loaded pattern.
  assign w_src       = load ? pat_in : r_pat;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state     <= S_IDLE;
      r_pat       <= DEFAULT_PAT;
      r_shreg     <= '0;
      r_rep       <= '0;
      r_gap_len   <= '0;
      r_gap_cnt   <= '0;
      r_bit_cnt   <= '0;
      dout        <= IDLE_BIT;
      busy        <= 1'b0;
      frame_start <= 1'b0;
      done        <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_pat       <= w_pat_n;
      r_shreg     <= w_shreg_n;
      r_rep       <= w_rep_n;
      r_gap_len   <= w_gap_len_n;
      r_gap_cnt   <= w_gap_cnt_n;
      r_bit_cnt   <= w_bit_cnt_n;
      dout        <= w_dout_n;
      busy        <= w_busy_n;
      frame_start <= w_fs_n;
      done        <= w_done_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_pat_n     = r_pat;
    w_shreg_n   = r_shreg;
    w_rep_n     = r_rep;
    w_gap_len_n = r_gap_len;
    w_gap_cnt_n = r_gap_cnt;
    w_bit_cnt_n = r_bit_cnt;
    w_dout_n    = IDLE_BIT;
    w_fs_n      = 1'b0;
    w_done_n    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (load) w_pat_n = pat_in;
        if (start) begin
          w_shreg_n   = w_src;
          w_rep_n     = repeat_n;
          w_gap_len_n = gap;
          w_bit_cnt_n = BCW'(WIDTH - 1);
          w_dout_n    = w_src[WIDTH-1];
          w_fs_n      = 1'b1;
          w_state_n   = S_SEND;
        end
      end
      S_SEND: begin
        // dout always mirrors shreg MSB while sending.
        if (r_bit_cnt != '0) begin
          w_shreg_n   = {r_shreg[WIDTH-2:0], IDLE_BIT};
          w_bit_cnt_n = r_bit_cnt - 1'b1;
          w_dout_n    = r_shreg[WIDTH-2];
        end else if (r_rep == '0) begin
          w_done_n  = 1'b1;
          w_state_n = S_IDLE;
        end else if (r_gap_len == '0) begin
          w_rep_n     = r_rep - 1'b1;
          w_shreg_n   = r_pat;
          w_bit_cnt_n = BCW'(WIDTH - 1);
          w_dout_n    = r_pat[WIDTH-1];
          w_fs_n      = 1'b1;
        end else begin
          w_rep_n     = r_rep - 1'b1;
          w_gap_cnt_n = r_gap_len - 1'b1;
          w_state_n   = S_GAP;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == '0) begin
          w_shreg_n   = r_pat;
          w_bit_cnt_n = BCW'(WIDTH - 1);
          w_dout_n    = r_pat[WIDTH-1];
          w_fs_n      = 1'b1;
          w_state_n   = S_SEND;
        end else begin
          w_gap_cnt_n = r_gap_cnt - 1'b1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
    w_busy_n = (w_state_n != S_IDLE);
  end

endmodule

// File: tb/tb_seqgen_tx.sv
// Directed bench for seqgen_tx: hand-computed bit streams, busy lengths,
// a reference 10001 detector on the loopback stream, and async clear.
module tb_seqgen_tx;

  logic       clk;
  logic       clr;
  logic       load;
  logic [4:0] pat_in;
  logic       start;
  logic [3:0] repeat_n;
  logic [3:0] gap;
  logic       dout;
  logic       busy;
  logic       frame_start;
  logic       done;
  logic [1:0] o_dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  seqgen_tx dut (
    .clk         (clk),
    .clr         (clr),
    .load        (load),
    .pat_in      (pat_in),
    .start       (start),
    .repeat_n    (repeat_n),
    .gap         (gap),
    .dout        (dout),
    .busy        (busy),
    .frame_start (frame_start),
    .done        (done),
    .o_dbg_state (o_dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Steps one clock before each cycle check; expected vectors list the first
  // cycle in their most significant used bit. start/load drop after the first
  // edge unless keep_start is set.
  task automatic run_expect(input string tag, input int n, input logic [31:0] dv,
                            input logic [31:0] bv, input logic [31:0] fv,
                            input logic [31:0] dnv, input bit keep_start);
    for (int i = 0; i < n; i++) begin
      step();
      if (i == 0 && !keep_start) begin
        start = 1'b0;
        load  = 1'b0;
      end
      chk($sformatf("%s[%0d].dout", tag, i), 32'(dout), 32'(dv[n-1-i]));
      chk($sformatf("%s[%0d].busy", tag, i), 32'(busy), 32'(bv[n-1-i]));
      chk($sformatf("%s[%0d].frame_start", tag, i), 32'(frame_start), 32'(fv[n-1-i]));
      chk($sformatf("%s[%0d].done", tag, i), 32'(done), 32'(dnv[n-1-i]));
    end
  endtask

  task automatic measure_busy(input string tag, input logic [3:0] rn, input logic [3:0] gp,
                              input int exp_cycles);
    int cnt;
    repeat_n = rn;
    gap      = gp;
    start    = 1'b1;
    step();
    start = 1'b0;
    cnt = 0;
    while (busy && cnt < 200) begin
      cnt++;
      step();
    end
    chk({tag, ".busy_cycles"}, 32'(cnt), 32'(exp_cycles));
    chk({tag, ".done_after"}, 32'(done), 32'd1);
    step();
  endtask

  initial begin
    logic [4:0] hist;
    int         det_cnt;
    int         det_pos[2];

    clr = 1'b0; load = 1'b0; pat_in = '0; start = 1'b0; repeat_n = '0; gap = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.dout", 32'(dout), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.frame_start", 32'(frame_start), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk("reset.state", 32'(o_dbg_state), 32'd0);
    clr = 1'b1;
    step();

    // Default pattern sent once.
    start = 1'b1;
    run_expect("t1", 7, 32'b1000100, 32'b1111100, 32'b1000000, 32'b0000010, 1'b0);

    // Load a new pattern while idle, then send it twice.
    load = 1'b1; pat_in = 5'b11010;
    step();
    load = 1'b0;
    chk("t2.load_idle_dout", 32'(dout), 32'd0);
    chk("t2.load_idle_busy", 32'(busy), 32'd0);
    start = 1'b1;
    run_expect("t2a", 7, 32'b1101000, 32'b1111100, 32'b1000000, 32'b0000010, 1'b0);
    start = 1'b1;
    run_expect("t2b", 7, 32'b1101000, 32'b1111100, 32'b1000000, 32'b0000010, 1'b0);

    // Load+start together restores 10001; three contiguous frames.
    load = 1'b1; pat_in = 5'b10001; start = 1'b1; repeat_n = 4'd2; gap = 4'd0;
    run_expect("t3", 17, 32'b10001100011000100, 32'b11111111111111100,
               32'b10000100001000000, 32'b00000000000000010, 1'b0);

    // Two frames separated by a 3-cycle gap.
    start = 1'b1; repeat_n = 4'd1; gap = 4'd3;
    run_expect("t4", 15, 32'b100010001000100, 32'b111111111111100,
               32'b100000001000000, 32'b000000000000010, 1'b0);

    // start held high: a new frame begins from the done cycle.
    start = 1'b1; repeat_n = 4'd0; gap = 4'd0;
    run_expect("t7a", 7, 32'b1000101, 32'b1111101, 32'b1000001, 32'b0000010, 1'b1);
    start = 1'b0;
    run_expect("t7b", 5, 32'b00010, 32'b11110, 32'b00000, 32'b00001, 1'b0);

    // Loopback through a reference 10001 detector: one hit per frame.
    start = 1'b1; repeat_n = 4'd1; gap = 4'd2;
    step();
    start = 1'b0;
    hist = '0; det_cnt = 0; det_pos[0] = 0; det_pos[1] = 0;
    for (int c = 1; c <= 16; c++) begin
      hist = {hist[3:0], dout};
      if (hist == 5'b10001) begin
        if (det_cnt < 2) det_pos[det_cnt] = c;
        det_cnt++;
      end
      step();
    end
    chk("t6.det_count", 32'(det_cnt), 32'd2);
    chk("t6.det_pos0", 32'(det_pos[0]), 32'd5);
    chk("t6.det_pos1", 32'(det_pos[1]), 32'd12);

    // Counter extremes and gap ignored when there is no repetition.
    measure_busy("b1", 4'd1, 4'd15, 25);
    measure_busy("b2", 4'd15, 4'd0, 80);
    measure_busy("b3", 4'd0, 4'd15, 5);
    measure_busy("b4", 4'd2, 4'd1, 17);

    // Mid-frame start/load ignored, then async clear aborts the frame.
    load = 1'b1; pat_in = 5'b11100;
    step();
    load = 1'b0;
    start = 1'b1; repeat_n = 4'd0; gap = 4'd0;
    step();
    start = 1'b0;
    chk("t5.bit1", 32'(dout), 32'd1);
    chk("t5.fs1", 32'(frame_start), 32'd1);
    start = 1'b1; load = 1'b1; pat_in = 5'b00000; repeat_n = 4'd3;
    step();
    chk("t5.bit2", 32'(dout), 32'd1);
    chk("t5.fs2", 32'(frame_start), 32'd0);
    chk("t5.busy2", 32'(busy), 32'd1);
    step();
    chk("t5.bit3", 32'(dout), 32'd1);
    start = 1'b0; load = 1'b0; repeat_n = 4'd0;
    #2 clr = 1'b0;
    #1;
    chk("t5.clr_dout", 32'(dout), 32'd0);
    chk("t5.clr_busy", 32'(busy), 32'd0);
    chk("t5.clr_state", 32'(o_dbg_state), 32'd0);
    step();
    chk("t5.clr_hold_dout", 32'(dout), 32'd0);
    #2 clr = 1'b1;
    step();
    chk("t5.idle_busy", 32'(busy), 32'd0);
    start = 1'b1;
    run_expect("t5r", 7, 32'b1000100, 32'b1111100, 32'b1000000, 32'b0000010, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
